// File: rtl/fir_interp_polyphase.sv
// Polyphase FIR interpolator. Every sample accepted on the valid/ready
// handshake produces N_PHASES output samples on consecutive enabled cycles.
// Phase p uses the coefficients at addresses p*N_TAPS .. p*N_TAPS+N_TAPS-1.
//
// Ports
//   clock         rising-edge system clock
//   i_reset       synchronous active-high reset, takes priority over everything
//   i_enable      global clock enable; low freezes state, clears o_valid/o_sat
//   i_valid       input sample valid
//   o_ready       sample accepted at the next edge when i_valid is also high
//   i_data        signed input sample
//   i_round       1 = round half-up, 0 = truncate
//   i_coeff_we    coefficient write strobe (works regardless of i_enable)
//   i_coeff_addr  coefficient address = phase*N_TAPS + tap
//   i_coeff_data  signed coefficient value
//   o_data        signed output sample
//   o_valid       o_data valid, one cycle per output sample
//   o_sat         o_data was clipped, qualified by o_valid
module fir_interp_polyphase #(
   parameter int NB_INPUT   = 8,
   parameter int NBF_INPUT  = 7,
   parameter int NB_OUTPUT  = 8,
   parameter int NBF_OUTPUT = 7,
   parameter int NB_COEFF   = 8,
   parameter int NBF_COEFF  = 7,
   parameter int N_PHASES   = 4,
   parameter int N_TAPS     = 6,
   parameter int NB_CADDR   = 5,
   parameter int NB_GUARD   = 3
) (
   input  logic                        clock,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic signed [NB_INPUT-1:0]  i_data,
   input  logic                        i_round,
   input  logic                        i_coeff_we,
   input  logic [NB_CADDR-1:0]         i_coeff_addr,
   input  logic signed [NB_COEFF-1:0]  i_coeff_data,
   output logic signed [NB_OUTPUT-1:0] o_data,
   output logic                        o_valid,
   output logic                        o_sat
);

   localparam int N_COEF  = N_PHASES * N_TAPS;
   localparam int NB_PROD = NB_INPUT + NB_COEFF;
   localparam int NB_ACC  = NB_PROD + NB_GUARD + 1;
   localparam int NBF_ACC = NBF_INPUT + NBF_COEFF;
   localparam int N_DROP  = NBF_ACC - NBF_OUTPUT;
   localparam int NB_PH   = $clog2(N_PHASES);
   localparam int NB_CIDX = $clog2(N_COEF);

   localparam logic [NB_PH-1:0]         LAST_PH    = NB_PH'(N_PHASES - 1);
   localparam logic [NB_CADDR:0]        COEF_LIMIT = (NB_CADDR + 1)'(N_COEF);
   localparam logic signed [NB_ACC-1:0] ROUND_HALF = NB_ACC'(1) << (N_DROP - 1);
   localparam logic signed [NB_ACC-1:0] OUT_MAX    = NB_ACC'(2 ** (NB_OUTPUT - 1) - 1);
   localparam logic signed [NB_ACC-1:0] OUT_MIN    = ~OUT_MAX;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                     state, state_next;
   logic [NB_PH-1:0]           phase, phase_next;
   logic signed [NB_INPUT-1:0] taps  [N_TAPS];
   logic signed [NB_COEFF-1:0] coeff [N_COEF];
   logic                       handshake;

   logic signed [NB_PROD-1:0]   prod;
   logic signed [NB_ACC-1:0]    acc, acc_rnd, acc_shr;
   logic [NB_CIDX-1:0]          cidx;
   logic signed [NB_OUTPUT-1:0] sat_data;
   logic                        sat_flag;

   assign o_ready   = i_enable & ((state == IDLE) | ((state == RUN) & (phase == LAST_PH)));
   assign handshake = i_valid & o_ready;

   // Coefficient store: writable even while i_enable is low.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         for (int unsigned a = 0; a < N_COEF; a++) coeff[a] <= '0;
      end else if (i_coeff_we && ({1'b0, i_coeff_addr} < COEF_LIMIT)) begin
         coeff[NB_CIDX'(i_coeff_addr)] <= i_coeff_data;
      end
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state <= IDLE;
         phase <= '0;
      end else if (i_enable) begin
         state <= state_next;
         phase <= phase_next;
      end
   end

   always_comb begin
      state_next = state;
      phase_next = phase;
      case (state)
         IDLE: begin
            if (handshake) begin
               state_next = RUN;
               phase_next = '0;
            end
         end
         RUN: begin
            if (phase == LAST_PH) begin
               phase_next = '0;
               state_next = handshake ? RUN : IDLE;
            end else begin
               phase_next = phase + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            phase_next = '0;
         end
      endcase
   end

   // Dot product of the current phase's coefficients with the delay line,
   // then optional half-up rounding, LSB drop and clipping.
   always_comb begin
      acc  = '0;
      prod = '0;
      cidx = '0;
      for (int unsigned k = 0; k < N_TAPS; k++) begin
         cidx = NB_CIDX'(32'(phase) * N_TAPS + k);
         prod = NB_PROD'(coeff[cidx]) * NB_PROD'(taps[k]);
         acc  = acc + NB_ACC'(prod);
      end
      acc_rnd  = acc + (i_round ? ROUND_HALF : '0);
      acc_shr  = acc_rnd >>> N_DROP;
      sat_flag = 1'b0;
      sat_data = acc_shr[NB_OUTPUT-1:0];
      if (acc_shr > OUT_MAX) begin
         sat_flag = 1'b1;
         sat_data = OUT_MAX[NB_OUTPUT-1:0];
      end else if (acc_shr < OUT_MIN) begin
         sat_flag = 1'b1;
         sat_data = OUT_MIN[NB_OUTPUT-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         for (int unsigned k = 0; k < N_TAPS; k++) taps[k] <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_sat   <= 1'b0;
      end else if (i_enable) begin
         if (handshake) begin
            for (int unsigned k = N_TAPS - 1; k > 0; k--) taps[k] <= taps[k-1];
            taps[0] <= i_data;
         end
         if (state == RUN) begin
            o_data  <= sat_data;
            o_valid <= 1'b1;
            o_sat   <= sat_flag;
         end else begin
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
         end
      end else begin
         o_valid <= 1'b0;
         o_sat   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_interp_polyphase.sv
module tb_fir_interp_polyphase;

   localparam int NP = 4;
   localparam int NT = 6;
   localparam int NC = NP * NT;

   logic              clock = 1'b0;
   logic              i_reset = 1'b1;
   logic              i_enable = 1'b1;
   logic              i_valid = 1'b0;
   logic              o_ready;
   logic signed [7:0] i_data = '0;
   logic              i_round = 1'b0;
   logic              i_coeff_we = 1'b0;
   logic [4:0]        i_coeff_addr = '0;
   logic signed [7:0] i_coeff_data = '0;
   logic signed [7:0] o_data;
   logic              o_valid;
   logic              o_sat;

   always #5 clock = ~clock;

   fir_interp_polyphase #(
      .N_PHASES (NP),
      .N_TAPS   (NT)
   ) dut (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_data       (i_data),
      .i_round      (i_round),
      .i_coeff_we   (i_coeff_we),
      .i_coeff_addr (i_coeff_addr),
      .i_coeff_data (i_coeff_data),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_sat        (o_sat)
   );

   int checks = 0;
   int failures = 0;
   int coef [NC];
   int hist [NT];
   int exp_q[$];
   bit exp_sat_q[$];
   int got_q[$];
   bit gsat_q[$];
   int cyc = 0;
   int run_len = 0;
   int last_run = 0;
   int acc_cyc = 0;
   bit cur_round = 1'b0;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: history of accepted samples (newest first) dotted with
   // each phase's coefficient row, Q14 sum scaled to Q7 with floor, clipped.
   function automatic void model_accept(input int d);
      for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      for (int p = 0; p < NP; p++) begin
         longint s = 0;
         for (int k = 0; k < NT; k++) s += longint'(coef[p*NT+k]) * hist[k];
         if (cur_round) s += 64;
         s = s >>> 7;
         exp_sat_q.push_back(s > 127 || s < -128);
         if (s > 127) s = 127;
         if (s < -128) s = -128;
         exp_q.push_back(int'(s));
      end
   endfunction

   function automatic void model_reset();
      for (int a = 0; a < NC; a++) coef[a] = 0;
      for (int k = 0; k < NT; k++) hist[k] = 0;
      exp_q.delete();
      exp_sat_q.delete();
   endfunction

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (i_reset) begin
         run_len = 0;
      end else if (o_valid === 1'b1) begin
         run_len++;
         got_q.push_back(int'(o_data));
         gsat_q.push_back(o_sat);
         if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
         else begin
            chk("data", o_data, exp_q.pop_front());
            chk("sat", o_sat, exp_sat_q.pop_front());
         end
      end else begin
         if (run_len > 0) last_run = run_len;
         run_len = 0;
      end
   end

   task automatic send(input int d);
      bit ok = 1'b0;
      i_valid = 1'b1;
      i_data  = 8'(d);
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clock);
         if (o_ready === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         chk("ready_timeout", 0, 1);
         i_valid = 1'b0;
         return;
      end
      acc_cyc = cyc;
      model_accept(d);
      @(posedge clock); #1;
      i_valid = 1'b0;
   endtask

   task automatic wcoef(input int a, input int v);
      i_coeff_we   = 1'b1;
      i_coeff_addr = 5'(a);
      i_coeff_data = 8'(v);
      @(posedge clock); #1;
      i_coeff_we = 1'b0;
      if (a < NC) coef[a] = v;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic clear_logs();
      got_q.delete();
      gsat_q.delete();
   endtask

   task automatic run_t1(input bit stall, input bit load);
      if (load) for (int a = 0; a < NC; a++) wcoef(a, 2 * a);
      cur_round = 1'b0;
      i_round   = 1'b0;
      clear_logs();
      send(64);
      send(0);
      if (stall) begin
         i_enable = 1'b0;
         for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("stall_valid", o_valid, 0);
            chk("stall_ready", o_ready, 0);
         end
         i_enable = 1'b1;
      end
      for (int i = 0; i < 4; i++) send(0);
      drain();
      chk("t1_count", got_q.size(), 24);
      for (int i = 0; i < got_q.size() && i < 24; i++)
         chk("t1_seq", got_q[i], (i % 4) * 6 + i / 4);
      if (!stall) chk("t1_run", last_run, 24);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      i_reset = 1'b0;
      chk("rst_data", o_data, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_sat", o_sat, 0);
      chk("rst_ready", o_ready, 1);

      // impulse response, then the same burst with a 3-cycle stall
      run_t1(1'b0, 1'b1);
      run_t1(1'b1, 1'b0);

      // throughput: back-to-back samples
      clear_logs();
      prev = 0;
      for (int i = 0; i < 10; i++) begin
         send(int'($urandom_range(0, 255)) - 128);
         if (i > 0) chk("ready_period", acc_cyc - prev, NP);
         prev = acc_cyc;
      end
      drain();
      chk("t4_run", last_run, 40);
      chk("t4_idle_ready", o_ready, 1);
      chk("t4_idle_valid", o_valid, 0);

      // saturation both ways
      for (int a = 0; a < NC; a++) wcoef(a, 127);
      clear_logs();
      for (int i = 0; i < 6; i++) send(127);
      drain();
      chk("t2_pos_data", got_q.size() > 0 ? got_q[got_q.size()-1] : 999, 127);
      chk("t2_pos_sat", gsat_q.size() > 0 ? gsat_q[gsat_q.size()-1] : 0, 1);
      clear_logs();
      for (int i = 0; i < 6; i++) send(-128);
      drain();
      chk("t2_neg_data", got_q.size() > 0 ? got_q[got_q.size()-1] : 999, -128);
      chk("t2_neg_sat", gsat_q.size() > 0 ? gsat_q[gsat_q.size()-1] : 0, 1);

      // rounding
      for (int a = 0; a < NC; a++) wcoef(a, 0);
      wcoef(0, 1);
      clear_logs();
      send(64);
      drain();
      chk("t3_trunc", got_q.size() > 0 ? got_q[0] : 999, 0);
      chk("t3_trunc_sat", gsat_q.size() > 0 ? gsat_q[0] : 1, 0);
      cur_round = 1'b1;
      i_round   = 1'b1;
      clear_logs();
      send(64);
      drain();
      chk("t3_round", got_q.size() > 0 ? got_q[0] : 999, 1);
      chk("t3_round_sat", gsat_q.size() > 0 ? gsat_q[0] : 1, 0);
      cur_round = 1'b0;
      i_round   = 1'b0;

      // reset mid-run at phase 2, with a coefficient write that must lose
      for (int a = 0; a < NC; a++) wcoef(a, 2 * a);
      send(64);
      @(posedge clock);
      @(posedge clock); #1;
      i_reset      = 1'b1;
      i_coeff_we   = 1'b1;
      i_coeff_addr = 5'd0;
      i_coeff_data = 8'sd127;
      @(posedge clock); #1;
      i_reset    = 1'b0;
      i_coeff_we = 1'b0;
      model_reset();
      chk("t6_valid", o_valid, 0);
      chk("t6_data", o_data, 0);
      chk("t6_ready", o_ready, 1);
      chk("t6_sat", o_sat, 0);
      clear_logs();
      send(64);
      drain();
      chk("t6_zero_coef", got_q.size() > 0 ? got_q[0] : 999, 0);
      // reload with the enable low; out-of-range writes must be dropped
      i_enable = 1'b0;
      for (int a = 0; a < NC; a++) wcoef(a, 2 * a);
      for (int a = NC; a < 32; a++) wcoef(a, 85);
      i_enable = 1'b1;
      for (int i = 0; i < 5; i++) send(0);
      drain();
      run_t1(1'b0, 1'b0);

      // randomized coefficients and samples with random gaps, both rounding modes
      for (int r = 0; r < 2; r++) begin
         cur_round = r[0];
         i_round   = r[0];
         for (int a = 0; a < NC; a++) wcoef(a, int'($urandom_range(0, 255)) - 128);
         clear_logs();
         for (int i = 0; i < 30; i++) begin
            send(int'($urandom_range(0, 255)) - 128);
            repeat ($urandom_range(0, 4)) @(posedge clock);
            #1;
         end
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
